// File: rtl/spi_tx_queue_pkg.sv
// Shared definitions for the SPI transmit feeder: FSM states, byte width, default fill byte.
package spi_tx_queue_pkg;

  localparam int BYTE_W = 8;
  localparam logic [BYTE_W-1:0] FILL_DEFAULT = 8'h00;

  typedef enum logic [1:0] {
    RESYNC   = 2'd0,
    IDLE     = 2'd1,
    WAIT_ACK = 2'd2
  } state_t;

endpackage

// File: rtl/spi_tx_queue_if.sv
// Producer-side byte stream into the SPI transmit queue.
// Handshake: a beat transfers on a rising clk edge where in_valid && in_ready; in_data is
// held by the producer while in_valid is high, and in_ready never depends on in_valid.
interface spi_tx_queue_if;
  import spi_tx_queue_pkg::*;

  logic [BYTE_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);

endinterface

// File: rtl/spi_tx_queue_sync_ff.sv
// Generic N-stage single-bit synchronizer; reusable by any CDC block in the SPI slice.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk) begin
    if (rst) ff <= '0;
    else     ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/spi_tx_queue.sv
// System-clock feeder: byte FIFO plus two-phase toggle handshake to the SPI-clock importer.
// Optional build macro SPI_TX_QUEUE_FILL_EN sends one FILL byte whenever the queue drains.
module spi_tx_queue
  import spi_tx_queue_pkg::*;
#(
  parameter int                DEPTH       = 4,
  parameter int                SYNC_STAGES = 2,
  parameter logic [BYTE_W-1:0] FILL        = FILL_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  spi_tx_queue_if.slave          prod,
  output logic [$clog2(DEPTH):0] level,
  output logic                   busy,
  output logic [BYTE_W-1:0]      cdc_data,
  output logic                   cdc_req,
  input  logic                   cdc_ack,
  output state_t                 dbg_state
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int CW = $clog2(SYNC_STAGES + 1) + 1;

  logic [BYTE_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic              push;
  logic              pop;
  logic              ack_s;

  state_t            state;
  state_t            state_d;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     cnt_d;
  logic              req_d;
  logic [BYTE_W-1:0] data_d;

`ifdef SPI_TX_QUEUE_FILL_EN
  logic              last_fill;
  logic              last_fill_d;
`else
  logic              unused_fill;
  assign unused_fill = ^FILL;
`endif

  sync_ff #(.STAGES(SYNC_STAGES)) u_ack_sync (
    .clk (clk),
    .rst (rst),
    .d   (cdc_ack),
    .q   (ack_s)
  );

  // in_ready looks only at the registered level, so a pop never frees a slot in the same cycle.
  assign prod.in_ready = (level != LW'(DEPTH));
  assign push          = prod.in_valid && prod.in_ready;
  assign busy          = (state != IDLE);
  assign dbg_state     = state;

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    req_d   = cdc_req;
    data_d  = cdc_data;
    pop     = 1'b0;
`ifdef SPI_TX_QUEUE_FILL_EN
    last_fill_d = last_fill;
`endif
    case (state)
      RESYNC: begin
        // Adopt the importer's settled ack so nothing looks outstanding after reset.
        if (cnt == CW'(SYNC_STAGES)) begin
          req_d   = ack_s;
          state_d = IDLE;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      IDLE: begin
        if (level != '0) begin
          data_d  = mem[rd_ptr];
          pop     = 1'b1;
          req_d   = ~cdc_req;
          state_d = WAIT_ACK;
`ifdef SPI_TX_QUEUE_FILL_EN
          last_fill_d = 1'b0;
`endif
        end
`ifdef SPI_TX_QUEUE_FILL_EN
        else if (!last_fill) begin
          data_d      = FILL;
          req_d       = ~cdc_req;
          state_d     = WAIT_ACK;
          last_fill_d = 1'b1;
        end
`endif
      end
      WAIT_ACK: begin
        if (ack_s == cdc_req) state_d = IDLE;
      end
      default: state_d = RESYNC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RESYNC;
      cnt      <= '0;
      cdc_req  <= 1'b0;
      cdc_data <= '0;
      level    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
`ifdef SPI_TX_QUEUE_FILL_EN
      last_fill <= 1'b1;
`endif
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      cdc_req  <= req_d;
      cdc_data <= data_d;
      level    <= level + LW'(push) - LW'(pop);
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
`ifdef SPI_TX_QUEUE_FILL_EN
      last_fill <= last_fill_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= prod.in_data;
  end

endmodule

// File: tb/tb_spi_tx_queue.sv
// Self-checking bench for spi_tx_queue: directed handshake cases plus randomized traffic
// against an emulated SPI-side importer that scores every imported byte.
module tb_spi_tx_queue;
  import spi_tx_queue_pkg::*;

  localparam int              DEPTH  = 4;
  localparam int              SS     = 2;
  localparam logic [7:0]      FILL_V = 8'hFF;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [$clog2(DEPTH):0] level;
  logic                   busy;
  logic [7:0]             cdc_data;
  logic                   cdc_req;
  logic                   cdc_ack;
  state_t                 dbg_state;

  spi_tx_queue_if prod_if ();

  spi_tx_queue #(
    .DEPTH       (DEPTH),
    .SYNC_STAGES (SS),
    .FILL        (FILL_V)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .prod      (prod_if),
    .level     (level),
    .busy      (busy),
    .cdc_data  (cdc_data),
    .cdc_req   (cdc_req),
    .cdc_ack   (cdc_ack),
    .dbg_state (dbg_state)
  );

  // scoreboard
  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] exp_q[$];
  int         n_data = 0;
  int         ack_cyc = 0;
  logic       imp_en = 1'b0;
  logic       imp_rand = 1'b0;
  int         imp_delay = 5;
`ifdef SPI_TX_QUEUE_FILL_EN
  logic       m_last_fill = 1'b1;
  int         n_fill = 0;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // driver tasks
  task automatic drive_beat(input logic [7:0] b, output logic ok);
    prod_if.in_data  = b;
    prod_if.in_valid = 1'b1;
    ok = prod_if.in_ready;
    if (ok) exp_q.push_back(b);
    @(negedge clk);
  endtask

  task automatic wait_idle(input int budget);
    int stable = 0;
    int n = 0;
    while (stable < 4 && n < budget) begin
      @(negedge clk);
      n++;
      if (level == 0 && !busy && cdc_req == cdc_ack) stable++;
      else stable = 0;
    end
    check("drain_done", stable >= 4, 1);
  endtask

  // Emulated SPI-side importer: sees req != ack, holds for a delay, then toggles ack.
  initial begin : importer
    logic [7:0] got;
    logic       req_seen;
    logic       is_fill;
    int         d;
    cdc_ack = 1'b1;
    forever begin
      @(negedge clk);
      if (imp_en && (cdc_req != cdc_ack)) begin
        got      = cdc_data;
        req_seen = cdc_req;
        d = imp_rand ? int'($urandom_range(0, 6)) : imp_delay;
        for (int i = 0; i < d; i++) begin
          @(negedge clk);
          check("data_stable", cdc_data, got);
          check("req_stable", cdc_req, req_seen);
        end
        is_fill = 1'b0;
`ifdef SPI_TX_QUEUE_FILL_EN
        is_fill = (got == FILL_V);
        if (is_fill) begin
          check("fill_not_repeated", m_last_fill, 0);
          n_fill++;
        end
        m_last_fill = is_fill;
`endif
        if (!is_fill) begin
          check("scoreboard_nonempty", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) check("import_data", got, exp_q.pop_front());
          n_data++;
        end
        cdc_ack = ~cdc_ack;
        ack_cyc = cyc;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog timeout CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $fatal(1, "timeout");
  end

  initial begin : main
    logic req0;
    logic req1;
    logic ok;
    int   n;
    int   base;
    int   pushed;
    logic [7:0] b;

    prod_if.in_valid = 1'b0;
    prod_if.in_data  = 8'h00;

    // reset with cdc_ack held at 1
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_req", cdc_req, 0);
    check("rst_data", cdc_data, 0);
    check("rst_level", level, 0);
    check("rst_busy", busy, 1);
    check("rst_in_ready", prod_if.in_ready, 1);
    check("rst_state", dbg_state, RESYNC);
    rst = 1'b0;
    repeat (SS) begin
      @(negedge clk);
      check("resync_busy", busy, 1);
    end
    @(negedge clk);
    check("resync_done_busy", busy, 0);
    check("resync_req", cdc_req, 1);
    check("resync_state", dbg_state, IDLE);
    repeat (10) begin
      @(negedge clk);
      check("no_spurious_req", cdc_req, 1);
      check("no_spurious_data", cdc_data, 0);
    end

    // single byte: launch latency and ack-to-idle time
    imp_rand  = 1'b0;
    imp_delay = 5;
    imp_en    = 1'b1;
    req0 = cdc_req;
    req1 = ~req0;
    drive_beat(8'hA5, ok);
    prod_if.in_valid = 1'b0;
    check("launch_not_early", cdc_req, req0);
    check("level_one", level, 1);
    @(negedge clk);
    check("launch_req", cdc_req, req1);
    check("launch_data", cdc_data, 8'hA5);
    check("launch_busy", busy, 1);
    check("launch_level", level, 0);
    n = 0;
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("ack_to_idle", cyc - ack_cyc, SS + 1);
    wait_idle(200);

    // fill to full with the importer stalled
    imp_en = 1'b0;
    base = n_data;
    for (int i = 1; i <= 4; i++) drive_beat(8'(i), ok);
    check("level_after4", level, 3);
    drive_beat(8'h05, ok);
    check("push5_accepted", ok, 1);
    check("level_full", level, DEPTH);
    check("in_ready_full", prod_if.in_ready, 0);
    drive_beat(8'h06, ok);
    check("push6_refused", ok, 0);
    check("level_still_full", level, DEPTH);
    prod_if.in_valid = 1'b0;
    imp_delay = 2;
    imp_en    = 1'b1;
    wait_idle(500);
    check("drain_count", n_data - base, 5);

    // push and launch on the same edge at level 2
    imp_en = 1'b0;
    base = n_data;
    drive_beat(8'h11, ok);
    drive_beat(8'h22, ok);
    drive_beat(8'h33, ok);
    prod_if.in_valid = 1'b0;
    check("level_two", level, 2);
    imp_delay = 1;
    imp_en    = 1'b1;
    n = 0;
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("idle_before_same_edge", busy, 0);
    req0 = cdc_req;
    req1 = ~req0;
    drive_beat(8'h44, ok);
    prod_if.in_valid = 1'b0;
    check("same_edge_level", level, 2);
    check("same_edge_launch", cdc_req, req1);
    wait_idle(500);
    check("same_edge_count", n_data - base, 4);

    // randomized traffic, many pointer wraps
    imp_rand = 1'b1;
    base   = n_data;
    pushed = 0;
    for (int c = 0; c < 400; c++) begin
      check("in_ready_rule", prod_if.in_ready, level != DEPTH);
      check("level_range", level <= DEPTH, 1);
`ifdef SPI_TX_QUEUE_FILL_EN
      b = 8'($urandom_range(0, 254));
`else
      b = 8'($urandom_range(0, 255));
`endif
      if ($urandom_range(0, 2) != 0) begin
        drive_beat(b, ok);
        if (ok) pushed++;
      end else begin
        prod_if.in_valid = 1'b0;
        @(negedge clk);
      end
    end
    prod_if.in_valid = 1'b0;
    wait_idle(3000);
    check("random_count", n_data - base, pushed);
    check("random_wraps", pushed >= 3 * DEPTH, 1);
    check("random_queue_empty", exp_q.size(), 0);

    // reset during WAIT_ACK with bytes queued
    imp_rand = 1'b0;
    imp_en   = 1'b0;
    for (int i = 0; i < 4; i++) drive_beat(8'hC1 + 8'(i), ok);
    prod_if.in_valid = 1'b0;
    check("pre_rst_level", level, 3);
    check("pre_rst_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_level", level, 0);
    check("mid_rst_req", cdc_req, 0);
    check("mid_rst_in_ready", prod_if.in_ready, 1);
    exp_q.delete();
`ifdef SPI_TX_QUEUE_FILL_EN
    m_last_fill = 1'b1;
`endif
    rst = 1'b0;
    repeat (SS + 1) @(negedge clk);
    check("post_rst_idle", busy, 0);
    check("post_rst_align", cdc_req, cdc_ack);
    req0 = cdc_req;
    repeat (20) begin
      @(negedge clk);
      check("post_rst_no_toggle", cdc_req, req0);
    end
    check("post_rst_level", level, 0);
    imp_delay = 3;
    imp_en    = 1'b1;
    base = n_data;
    drive_beat(8'h77, ok);
    prod_if.in_valid = 1'b0;
    wait_idle(300);
    check("post_rst_xfer", n_data - base, 1);

`ifdef SPI_TX_QUEUE_FILL_EN
    // one fill byte after draining, then silence
    base = n_fill;
    n    = n_data;
    drive_beat(8'h3C, ok);
    prod_if.in_valid = 1'b0;
    wait_idle(300);
    check("fill_data_count", n_data - n, 1);
    check("fill_count", n_fill - base, 1);
    req0 = cdc_req;
    repeat (30) begin
      @(negedge clk);
      check("fill_quiet", cdc_req, req0);
    end
`endif

    // final report
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/spi_tx_queue.md
# spi_tx_queue

System-clock-domain feeder for the SPI peripheral transmit path. Buffers bytes from a valid/ready producer (Wishbone register file or stream source) in a small FIFO. Hands the bytes one at a time across the clock-domain boundary to the SPI-clock-side transmitter via a two-phase toggle handshake (`cdc_data` / `cdc_req` / `cdc_ack`). The transmitter shifts out whatever byte it last imported.

## Interface
- `DEPTH`, 4: FIFO depth in bytes; power of two, ≥2.
- `SYNC_STAGES`, 2: flip-flops in the `cdc_ack` synchronizer; ≥2.
- `FILL`, 8'h00: byte sent when the queue drains; used only with `SPI_TX_QUEUE_FILL_EN`.

Ports (one clock, `clk`; reset `rst` is synchronous, active-high):
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous active-high reset.
- `in_data`  in  8  byte from producer.
- `in_valid`  in  1  `in_data` valid.
- `in_ready`  out  1  FIFO not full.
- `level`  out  $clog2(DEPTH)+1  bytes currently queued, 0..DEPTH.
- `busy`  out  1  handshake in flight (state ≠ IDLE).
- `cdc_data`  out  8  byte offered to SPI domain; registered.
- `cdc_req`  out  1  toggles once per offered byte; registered.
- `cdc_ack`  in  1  SPI-domain acknowledge toggle; asynchronous to `clk`.

## Operation
- **Push.** A beat is accepted on a rising edge with `in_valid && in_ready`. Write pointer advances modulo DEPTH.
- **`ack_s`.** This is `cdc_ack` after `SYNC_STAGES` flops.
- **States:**
  - RESYNC: entered on reset. Counts SYNC_STAGES+1 cycles. On the last cycle, sets `cdc_req <= ack_s` and goes to IDLE. This realigns with an importer whose ack was not reset.
  - IDLE: if FIFO non-empty:
    - `cdc_data <= head`
    - pop
    - `cdc_req <= ~cdc_req`
    - go to WAIT_ACK.
  - WAIT_ACK: `cdc_data` and `cdc_req` held stable. When `ack_s == cdc_req`, go to IDLE.
- **Pop.** Occurs only on the IDLE launch edge. Read pointer advances modulo DEPTH.
- **Level.**
  - Push and pop on the same edge: `level` unchanged.
  - Push into full: impossible, because `in_ready = (level != DEPTH)`.
  - `in_ready` reflects registered `level` only (no same-cycle pop bypass).
- **Pointers.** Width $clog2(DEPTH) and wrap naturally. `level` is a separate counter.
- **Reset values.**
  - Outputs: `cdc_req=0`, `cdc_data=0`, `level=0`, `busy=1` (RESYNC), `in_ready=1`.
  - Internal: synchronizer flops 0.
- **Reset mid-handshake.** The queued bytes and the in-flight byte are discarded; the importer may still latch the in-flight byte. Afterwards RESYNC makes `cdc_req` match the settled `ack_s`, so no spurious transfer is launched.

## Timing
- **Launch latency.** A byte accepted at edge E0 into an empty FIFO with the block in IDLE: launch registers update at E1. `cdc_req` toggles visibly after E1.
- **Per-byte cost in `clk` cycles.**
  - 1 launch cycle.
  - Import round trip.
  - SYNC_STAGES cycles.
  - 1 cycle to return to IDLE.
  - Back-to-back launches are never closer than SYNC_STAGES+2 cycles.
- **Data stability.** `cdc_data` is stable from the toggle edge until the acknowledging `ack_s` edge (the two-phase rule the importer relies on).
- **Out of range.** Throughput above the SPI byte rate is not required. Bytes the importer never requests stay queued.

## Configuration
- `SPI_TX_QUEUE_FILL_EN`
  - Defined: in IDLE with an empty FIFO, if the last launched byte was not a fill, launch one transfer of `FILL`. This stops the SPI side from repeating a stale data byte. A "last was fill" flag is set by that launch and cleared by any data launch; it resets to 1, so no fill is sent after reset.
  - Undefined: an empty FIFO in IDLE does nothing; the transmitter keeps repeating its last byte.

## Structure
- **Shared SPI package:**
  - the state enum (RESYNC, IDLE, WAIT_ACK);
  - the byte width constant (8);
  - the default `FILL` value.
- **Sub-module `sync_ff`.** Generic N-stage single-bit synchronizer, used for `cdc_ack`. It is reusable by other CDC blocks.
- FIFO storage and pointers stay inline.

## Test plan
- Reset, then `cdc_ack` held at 1: after SYNC_STAGES+1 cycles `cdc_req=1`, `busy=0`, and no data toggle occurs.
- Push 8'hA5 into an idle empty queue: `cdc_req` toggles at E1 with `cdc_data=8'hA5`. An emulated importer toggles `cdc_ack` after 5 cycles; `busy` drops SYNC_STAGES+1 cycles later.
- Push 8'h01..8'h04 back-to-back with the importer stalled:
  - `level` reaches 3, because one byte is already launched;
  - after the 5th push `level` reaches 4 and `in_ready=0`;
  - a 6th `in_valid` is not accepted;
  - draining yields the bytes in order 01,02,03,04,05.
- Push and launch on the same edge with `level`=2: `level` stays 2; the wrap-around of both pointers is exercised over 3×DEPTH bytes with no loss or reordering.
- Assert `rst` during WAIT_ACK with 3 bytes queued: `level=0`, and after RESYNC no toggle occurs until a new push.
- With `SPI_TX_QUEUE_FILL_EN` defined and `FILL=8'hFF`: push 8'h3C and drain. Exactly one further transfer of 8'hFF follows, then `cdc_req` is idle indefinitely.
